// File: rtl/onchip_ram_arbiter_pkg.sv
// Shared types and default sizes for the two-port on-chip RAM arbiter.
package onchip_ram_arbiter_pkg;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_RAM_LAT = 1;

   // Controller modes: sweeping the RAM to the fill value, or serving requesters.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Read-return tag travelling alongside the RAM read latency.
   typedef struct packed {
      logic valid;
      logic port;
   } tag_t;

endpackage

// File: rtl/onchip_ram_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On a tie, the port not granted last wins.
// A grant only happens while enabled, and a grant is always a handshake
// (ready == grant), so the last-grant pointer moves on every grant.
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);

   logic last_q;
   logic last_d;

   // Grant: a lone requester wins; a tie goes to the port not granted last.
   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
         end else begin
            grant_o = req_i;
         end
      end
   end

   // Pointer follows whichever port was just granted.
   always_comb begin
      last_d = last_q;
      if (grant_o[0]) begin
         last_d = 1'b0;
      end else if (grant_o[1]) begin
         last_d = 1'b1;
      end
   end

   // Pointer starts at port 1 so port 0 takes the first tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Shares one single-port RAM between two requesters. Sweeps the RAM to
// INIT_VAL after reset or i_clear, then serves round-robin requests and
// returns read data tagged with the requesting port.
module onchip_ram_arbiter
   import onchip_ram_arbiter_pkg::*;
#(
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                RAM_LAT  = DEF_RAM_LAT,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              i_sys_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   output logic              o_init_done,
   input  logic              i_req0_valid,
   input  logic              i_req0_we,
   input  logic [ADDR_W-1:0] i_req0_addr,
   input  logic [DATA_W-1:0] i_req0_wdata,
   output logic              o_req0_ready,
   output logic              o_req0_rvalid,
   output logic [DATA_W-1:0] o_req0_rdata,
   input  logic              i_req1_valid,
   input  logic              i_req1_we,
   input  logic [ADDR_W-1:0] i_req1_addr,
   input  logic [DATA_W-1:0] i_req1_wdata,
   output logic              o_req1_ready,
   output logic              o_req1_rvalid,
   output logic [DATA_W-1:0] o_req1_rdata,
   output logic              o_ram_en,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_din,
   input  logic [DATA_W-1:0] i_ram_dout
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [1:0]        grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   tag_t              push_tag;
   tag_t              tag_q [RAM_LAT];

   rr_arbiter2 u_rr (
      .clk_i   (i_sys_clk),
      .rst_ni  (i_rst_n),
      .en_i    (state_q == ST_RUN),
      .req_i   ({i_req1_valid, i_req0_valid}),
      .grant_o (grant)
   );

   assign o_req0_ready = grant[0];
   assign o_req1_ready = grant[1];

   // Both ports see the raw RAM output; rvalid says whose it is.
   assign o_req0_rdata = i_ram_dout;
   assign o_req1_rdata = i_ram_dout;

   // Granted port's request fields (port 0 when nobody is granted).
   assign sel_we    = grant[1] ? i_req1_we    : i_req0_we;
   assign sel_addr  = grant[1] ? i_req1_addr  : i_req0_addr;
   assign sel_wdata = grant[1] ? i_req1_wdata : i_req0_wdata;

   // State register: mode and sweep address.
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep every address once, i_clear always restarts the sweep.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (i_clear) begin
               cnt_d = '0;
            end else if (cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         ST_RUN: begin
            if (i_clear) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: sweep writes in INIT, granted request passes straight through in RUN.
   // The sweep is held off while reset is asserted so the RAM pins read idle.
   always_comb begin
      o_init_done = 1'b0;
      o_ram_en    = 1'b0;
      o_ram_we    = 1'b0;
      o_ram_addr  = cnt_q;
      o_ram_din   = '0;
      case (state_q)
         ST_INIT: begin
            o_ram_en  = i_rst_n;
            o_ram_we  = i_rst_n;
            o_ram_din = i_rst_n ? INIT_VAL : '0;
         end
         ST_RUN: begin
            o_init_done = 1'b1;
            o_ram_en    = |grant;
            o_ram_we    = (|grant) && sel_we;
            o_ram_addr  = sel_addr;
            o_ram_din   = sel_wdata;
         end
         default: ;
      endcase
   end

   // A read handshake launches a tag naming the port that gets the data.
   always_comb begin
      push_tag       = '0;
      push_tag.valid = (|grant) && !sel_we;
      push_tag.port  = grant[1];
   end

   // Tag pipe matches the RAM read latency; keeps shifting through INIT.
   for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
         // First stage captures the tag of this cycle's handshake.
         always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               tag_q[gi] <= '0;
            end else begin
               tag_q[gi] <= push_tag;
            end
         end
      end else begin : g_shift
         // Later stages just delay the tag by one more cycle.
         always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               tag_q[gi] <= '0;
            end else begin
               tag_q[gi] <= tag_q[gi-1];
            end
         end
      end
   end

   assign o_req0_rvalid = tag_q[RAM_LAT-1].valid && !tag_q[RAM_LAT-1].port;
   assign o_req1_rvalid = tag_q[RAM_LAT-1].valid &&  tag_q[RAM_LAT-1].port;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Self-checking bench for onchip_ram_arbiter with a behavioural RAM and
// a cycle-level reference model of the sweep, arbitration and read return.
module tb_onchip_ram_arbiter;

   localparam logic [15:0] INIT_V = 16'h0000;

   typedef struct {
      logic v0, we0; logic [7:0] a0; logic [15:0] d0;
      logic v1, we1; logic [7:0] a1; logic [15:0] d1;
      logic rdy0, rdy1, en, we; logic [7:0] addr;
      logic rv0, rv1; logic [15:0] rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        init_done;
   logic        req0_valid = 1'b0, req0_we = 1'b0, req0_ready, req0_rvalid;
   logic [7:0]  req0_addr = '0;
   logic [15:0] req0_wdata = '0, req0_rdata;
   logic        req1_valid = 1'b0, req1_we = 1'b0, req1_ready, req1_rvalid;
   logic [7:0]  req1_addr = '0;
   logic [15:0] req1_wdata = '0, req1_rdata;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_din, ram_dout;
   logic [15:0] ram_mem [256];

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [15:0] m_mem [256];
   bit          m_run;
   int          m_cnt;
   int          m_last;
   bit          m_rv0, m_rv1;
   logic [15:0] m_rdata;

   always #5 clk = ~clk;

   onchip_ram_arbiter dut (
      .i_sys_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_init_done(init_done),
      .i_req0_valid(req0_valid), .i_req0_we(req0_we), .i_req0_addr(req0_addr),
      .i_req0_wdata(req0_wdata), .o_req0_ready(req0_ready), .o_req0_rvalid(req0_rvalid),
      .o_req0_rdata(req0_rdata),
      .i_req1_valid(req1_valid), .i_req1_we(req1_we), .i_req1_addr(req1_addr),
      .i_req1_wdata(req1_wdata), .o_req1_ready(req1_ready), .o_req1_rvalid(req1_rvalid),
      .o_req1_rdata(req1_rdata),
      .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
      .o_ram_din(ram_din), .i_ram_dout(ram_dout)
   );

   // Single-port RAM, one-cycle registered read
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_din;
         else        ram_dout <= ram_mem[ram_addr];
      end
   end

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_run = 1'b0; m_cnt = 0; m_last = 1; m_rv0 = 1'b0; m_rv1 = 1'b0;
   endfunction

   task automatic check_reset_outputs(string tag);
      chk({tag, " init_done"}, init_done, 1'b0);
      chk({tag, " ram_en"}, ram_en, 1'b0);
      chk({tag, " ram_we"}, ram_we, 1'b0);
      chk({tag, " ram_addr"}, ram_addr, 8'h00);
      chk({tag, " ram_din"}, ram_din, 16'h0000);
      chk({tag, " ready0"}, req0_ready, 1'b0);
      chk({tag, " ready1"}, req1_ready, 1'b0);
      chk({tag, " rvalid0"}, req0_rvalid, 1'b0);
      chk({tag, " rvalid1"}, req1_rvalid, 1'b0);
   endtask

   // One clock cycle: drive, compare at negedge against the model (and the
   // table when tbl is set), then advance the model past the rising edge.
   task automatic run_cycle(input vec_t v, input bit tbl, input bit clr, output int gnt);
      logic        gwe;
      logic [7:0]  ga;
      logic [15:0] gd;
      req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
      req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
      clear = clr;
      gnt = -1;
      if (m_run) begin
         if (v.v0 && v.v1) gnt = 1 - m_last;
         else if (v.v0)    gnt = 0;
         else if (v.v1)    gnt = 1;
      end
      gwe = (gnt == 1) ? v.we1 : v.we0;
      ga  = (gnt == 1) ? v.a1  : v.a0;
      gd  = (gnt == 1) ? v.d1  : v.d0;
      @(negedge clk);
      chk("init_done", init_done, m_run);
      chk("ready0", req0_ready, gnt == 0);
      chk("ready1", req1_ready, gnt == 1);
      if (!m_run) begin
         chk("init_en", ram_en, 1'b1);
         chk("init_we", ram_we, 1'b1);
         chk("init_addr", ram_addr, m_cnt);
         chk("init_din", ram_din, INIT_V);
      end else if (gnt >= 0) begin
         chk("ram_en", ram_en, 1'b1);
         chk("ram_we", ram_we, gwe);
         chk("ram_addr", ram_addr, ga);
         if (gwe) chk("ram_din", ram_din, gd);
      end else begin
         chk("ram_en_idle", ram_en, 1'b0);
      end
      chk("rvalid0", req0_rvalid, m_rv0);
      chk("rvalid1", req1_rvalid, m_rv1);
      if (m_rv0) chk("rdata0", req0_rdata, m_rdata);
      if (m_rv1) chk("rdata1", req1_rdata, m_rdata);
      if (tbl) begin
         chk("tbl ready0", req0_ready, v.rdy0);
         chk("tbl ready1", req1_ready, v.rdy1);
         chk("tbl ram_en", ram_en, v.en);
         if (v.en) begin
            chk("tbl ram_we", ram_we, v.we);
            chk("tbl ram_addr", ram_addr, v.addr);
         end
         chk("tbl rvalid0", req0_rvalid, v.rv0);
         chk("tbl rvalid1", req1_rvalid, v.rv1);
         if (v.rv0) chk("tbl rdata0", req0_rdata, v.rdata);
         if (v.rv1) chk("tbl rdata1", req1_rdata, v.rdata);
      end
      @(posedge clk);
      #1;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
      if (!m_run) begin
         m_mem[m_cnt] = INIT_V;
         if (clr)              m_cnt = 0;
         else if (m_cnt == 255) begin m_run = 1'b1; m_cnt = 0; end
         else                  m_cnt++;
      end else begin
         if (gnt >= 0) begin
            if (gwe) m_mem[ga] = gd;
            else begin
               m_rdata = m_mem[ga];
               if (gnt == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
            end
            m_last = gnt;
         end
         if (clr) begin m_run = 1'b0; m_cnt = 0; end
      end
      $display("cyc t=%0t run=%0d gnt=%0d en=%0b we=%0b addr=%02h", $time, m_run, gnt, ram_en, ram_we, ram_addr);
   endtask

   task automatic idle_cycles(input int n);
      vec_t v;
      int   g;
      v = '{default: '0};
      for (int i = 0; i < n; i++) run_cycle(v, 1'b0, 1'b0, g);
   endtask

   task automatic pulse_reset(string tag);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs(tag);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   vec_t vecs [13];
   vec_t v;
   int   g;
   logic        r_v [2], r_we [2];
   logic [7:0]  r_a [2];
   logic [15:0] r_d [2];

   function automatic void new_req(int p);
      r_v[p]  = ($urandom_range(0, 3) != 0);
      r_we[p] = 1'($urandom_range(0, 1));
      r_a[p]  = 8'($urandom_range(0, 15));
      r_d[p]  = 16'($urandom);
   endfunction

   initial begin
      //          v0   we0   a0     d0        v1   we1   a1     d1        rdy0 rdy1 en   we   addr   rv0  rv1  rdata
      vecs[0]  = '{1'b1,1'b0,8'h7F,16'h0000, 1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b1,1'b0,8'h7F, 1'b0,1'b0,16'h0000};
      vecs[1]  = '{1'b1,1'b1,8'h10,16'hA5A5, 1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b1,1'b1,8'h10, 1'b1,1'b0,16'h0000};
      vecs[2]  = '{1'b1,1'b0,8'h10,16'h0000, 1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b1,1'b0,8'h10, 1'b0,1'b0,16'h0000};
      vecs[3]  = '{1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b1,8'h20,16'h5A5A, 1'b0,1'b1,1'b1,1'b1,8'h20, 1'b1,1'b0,16'hA5A5};
      vecs[4]  = '{1'b1,1'b0,8'h10,16'h0000, 1'b1,1'b0,8'h20,16'h0000, 1'b1,1'b0,1'b1,1'b0,8'h10, 1'b0,1'b0,16'h0000};
      vecs[5]  = '{1'b1,1'b0,8'h10,16'h0000, 1'b1,1'b0,8'h20,16'h0000, 1'b0,1'b1,1'b1,1'b0,8'h20, 1'b1,1'b0,16'hA5A5};
      vecs[6]  = '{1'b1,1'b0,8'h10,16'h0000, 1'b1,1'b0,8'h20,16'h0000, 1'b1,1'b0,1'b1,1'b0,8'h10, 1'b0,1'b1,16'h5A5A};
      vecs[7]  = '{1'b1,1'b0,8'h10,16'h0000, 1'b1,1'b0,8'h20,16'h0000, 1'b0,1'b1,1'b1,1'b0,8'h20, 1'b1,1'b0,16'hA5A5};
      vecs[8]  = '{1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,16'h5A5A};
      vecs[9]  = '{1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b1,8'hFF,16'h1234, 1'b0,1'b1,1'b1,1'b1,8'hFF, 1'b0,1'b0,16'h0000};
      vecs[10] = '{1'b1,1'b0,8'hFF,16'h0000, 1'b0,1'b0,8'h00,16'h0000, 1'b1,1'b0,1'b1,1'b0,8'hFF, 1'b0,1'b0,16'h0000};
      vecs[11] = '{1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,16'h1234};
      vecs[12] = '{1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,8'h00,16'h0000, 1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,16'h0000};

      // Reset state with a request already presented
      model_reset();
      req0_valid = 1'b1;
      #3 check_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Full init sweep, then the directed table
      idle_cycles(256);
      for (int i = 0; i < 13; i++) run_cycle(vecs[i], 1'b1, 1'b0, g);

      // Randomized traffic; a request is held until it is accepted
      for (int p = 0; p < 2; p++) new_req(p);
      for (int i = 0; i < 400; i++) begin
         v = '{default: '0};
         v.v0 = r_v[0]; v.we0 = r_we[0]; v.a0 = r_a[0]; v.d0 = r_d[0];
         v.v1 = r_v[1]; v.we1 = r_we[1]; v.a1 = r_a[1]; v.d1 = r_d[1];
         run_cycle(v, 1'b0, 1'b0, g);
         for (int p = 0; p < 2; p++) if (!r_v[p] || g == p) new_req(p);
      end

      // Clear in the same cycle as a port 1 read handshake
      v = '{default: '0};
      v.v0 = 1'b1; v.we0 = 1'b1; v.a0 = 8'h33; v.d0 = 16'hBEEF;
      run_cycle(v, 1'b0, 1'b0, g);
      v = '{default: '0};
      v.v1 = 1'b1; v.a1 = 8'h33;
      run_cycle(v, 1'b0, 1'b1, g);
      idle_cycles(256);
      v = '{default: '0};
      v.v0 = 1'b1; v.a0 = 8'h33;
      run_cycle(v, 1'b0, 1'b0, g);
      idle_cycles(1);

      // Reset while a read return is on the outputs
      v = '{default: '0};
      v.v1 = 1'b1; v.a1 = 8'h20;
      run_cycle(v, 1'b0, 1'b0, g);
      pulse_reset("rst_read");
      idle_cycles(258);

      // Reset in the middle of the sweep; first tie afterwards goes to port 0
      v = '{default: '0};
      run_cycle(v, 1'b0, 1'b1, g);
      idle_cycles(100);
      pulse_reset("rst_sweep");
      idle_cycles(256);
      v = '{default: '0};
      v.v0 = 1'b1; v.a0 = 8'h05; v.v1 = 1'b1; v.a1 = 8'h06;
      run_cycle(v, 1'b0, 1'b0, g);
      chk("tie_after_reset", g, 0);
      idle_cycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
